// File: rtl/beep_sched.sv
// beep_sched: fixed-priority scheduler for the shared piezo beeper.
// Arbitrates alarm > chime > click, sequences the selected pattern and
// drives a square-wave tone generator from the registered half-period.
module beep_sched #(
  parameter int unsigned CLICK_MS     = 30,
  parameter int unsigned NOTE_MS      = 400,
  parameter int unsigned GAP_MS       = 50,
  parameter int unsigned ALARM_ON_MS  = 250,
  parameter int unsigned ALARM_OFF_MS = 250,
  parameter int unsigned ALARM_BURSTS = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        alarm_req,
  input  logic        alarm_stop,
  input  logic        chime_req,
  input  logic        click_req,
  output logic        beep,
  output logic [15:0] tone_div,
  output logic [2:0]  grant,
  output logic        busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLICK      = 3'd1;
  localparam logic [2:0] S_CHIME_NOTE = 3'd2;
  localparam logic [2:0] S_CHIME_GAP  = 3'd3;
  localparam logic [2:0] S_ALARM_ON   = 3'd4;
  localparam logic [2:0] S_ALARM_OFF  = 3'd5;

  localparam logic [15:0] SILENT     = 16'hFFFF;
  localparam logic [15:0] CLICK_TONE = 16'h2F74;
  localparam logic [15:0] ALARM_TONE = 16'h2F74;

  localparam logic [15:0] CLICK_LAST = 16'(CLICK_MS - 1);
  localparam logic [15:0] NOTE_LAST  = 16'(NOTE_MS - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_MS - 1);
  localparam logic [15:0] ON_LAST    = 16'(ALARM_ON_MS - 1);
  localparam logic [15:0] OFF_LAST   = 16'(ALARM_OFF_MS - 1);

  localparam int unsigned BW = (ALARM_BURSTS > 1) ? $clog2(ALARM_BURSTS + 1) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(ALARM_BURSTS - 1);

  logic [2:0]    state, state_nxt;
  logic [15:0]   ms_cnt, ms_cnt_nxt;
  logic [2:0]    note_idx, note_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          alarm_pend, alarm_pend_nxt;
  logic          chime_pend, chime_pend_nxt;
  logic [15:0]   ms_last;
  logic          ms_done;
  logic          alarm_go, chime_go;
  logic          in_alarm, in_chime;
  logic [2:0]    grant_nxt;
  logic [15:0]   tone_nxt;
  logic [15:0]   tone_cnt;

  function automatic logic [15:0] melody(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h6A88;
      3'd1:    return 16'h8637;
      3'd2:    return 16'h7794;
      3'd3:    return 16'hB327;
      3'd4:    return 16'hB327;
      3'd5:    return 16'h7794;
      3'd6:    return 16'h6A88;
      default: return 16'h8637;
    endcase
  endfunction

  // Arbitration, sequencing and registered-output next values.
  always_comb begin
    in_alarm = (state == S_ALARM_ON) || (state == S_ALARM_OFF);
    in_chime = (state == S_CHIME_NOTE) || (state == S_CHIME_GAP);
    alarm_go = (alarm_req | alarm_pend) & ~alarm_stop;
    chime_go = chime_req | chime_pend;

    case (state)
      S_CLICK:      ms_last = CLICK_LAST;
      S_CHIME_NOTE: ms_last = NOTE_LAST;
      S_CHIME_GAP:  ms_last = GAP_LAST;
      S_ALARM_ON:   ms_last = ON_LAST;
      S_ALARM_OFF:  ms_last = OFF_LAST;
      default:      ms_last = '0;
    endcase
    ms_done = tick_ms && (ms_cnt == ms_last);

    state_nxt      = state;
    note_nxt       = note_idx;
    burst_nxt      = burst_cnt;
    alarm_pend_nxt = alarm_pend;
    chime_pend_nxt = chime_pend;

    if (alarm_stop) begin
      alarm_pend_nxt = 1'b0;
    end else if (alarm_req && !in_alarm) begin
      alarm_pend_nxt = 1'b1;
    end
    if (chime_req && !in_chime) begin
      chime_pend_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (alarm_go) begin
          state_nxt      = S_ALARM_ON;
          burst_nxt      = '0;
          alarm_pend_nxt = 1'b0;
        end else if (chime_go) begin
          state_nxt      = S_CHIME_NOTE;
          note_nxt       = '0;
          chime_pend_nxt = 1'b0;
        end else if (click_req) begin
          state_nxt = S_CLICK;
        end
      end
      S_CLICK, S_CHIME_NOTE, S_CHIME_GAP: begin
        if (alarm_go) begin
          state_nxt      = S_ALARM_ON;
          burst_nxt      = '0;
          alarm_pend_nxt = 1'b0;
        end else if (ms_done) begin
          if (state == S_CLICK) begin
            state_nxt = S_IDLE;
          end else if (state == S_CHIME_NOTE) begin
            state_nxt = S_CHIME_GAP;
          end else if (note_idx == 3'd7) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_CHIME_NOTE;
            note_nxt  = note_idx + 3'd1;
          end
        end
      end
      S_ALARM_ON: begin
        if (alarm_stop) begin
          state_nxt = S_IDLE;
        end else if (ms_done) begin
          state_nxt = S_ALARM_OFF;
        end
      end
      S_ALARM_OFF: begin
        if (alarm_stop) begin
          state_nxt = S_IDLE;
        end else if (ms_done) begin
          if (burst_cnt == BURST_LAST) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ALARM_ON;
            burst_nxt = burst_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if ((state_nxt != state) || (state_nxt == S_IDLE)) begin
      ms_cnt_nxt = '0;
    end else if (tick_ms) begin
      ms_cnt_nxt = ms_cnt + 16'd1;
    end else begin
      ms_cnt_nxt = ms_cnt;
    end

    case (state_nxt)
      S_CLICK:      begin grant_nxt = 3'b001; tone_nxt = CLICK_TONE;        end
      S_CHIME_NOTE: begin grant_nxt = 3'b010; tone_nxt = melody(note_nxt); end
      S_CHIME_GAP:  begin grant_nxt = 3'b010; tone_nxt = SILENT;            end
      S_ALARM_ON:   begin grant_nxt = 3'b100; tone_nxt = ALARM_TONE;        end
      S_ALARM_OFF:  begin grant_nxt = 3'b100; tone_nxt = SILENT;            end
      default:      begin grant_nxt = 3'b000; tone_nxt = SILENT;            end
    endcase
  end

  // Sequencer state, counters, pending flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ms_cnt     <= '0;
      note_idx   <= '0;
      burst_cnt  <= '0;
      alarm_pend <= 1'b0;
      chime_pend <= 1'b0;
      grant      <= '0;
      tone_div   <= SILENT;
    end else begin
      state      <= state_nxt;
      ms_cnt     <= ms_cnt_nxt;
      note_idx   <= note_nxt;
      burst_cnt  <= burst_nxt;
      alarm_pend <= alarm_pend_nxt;
      chime_pend <= chime_pend_nxt;
      grant      <= grant_nxt;
      tone_div   <= tone_nxt;
    end
  end

  // Square-wave generator: restarts on every half-period change, parks low when silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      beep     <= 1'b0;
    end else if (tone_nxt == SILENT) begin
      tone_cnt <= '0;
      beep     <= 1'b0;
    end else if (tone_nxt != tone_div) begin
      tone_cnt <= '0;
    end else if (tone_cnt == tone_div - 16'd1) begin
      tone_cnt <= '0;
      beep     <= ~beep;
    end else begin
      tone_cnt <= tone_cnt + 16'd1;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_beep_sched.sv
// tb_beep_sched: scenario bench for beep_sched. Expected behaviour is a list
// of (owner, half-period, length-in-ticks) segments derived from the pattern
// definitions; each segment is checked against the DUT as time advances.
`timescale 1ns/1ps
module tb_beep_sched;

  localparam int CLICK_MS = 3;
  localparam int NOTE_MS  = 4;
  localparam int GAP_MS   = 1;
  localparam int ON_MS    = 2;
  localparam int OFF_MS   = 2;
  localparam int BURSTS   = 3;

  localparam logic [15:0] SILENT = 16'hFFFF;
  localparam logic [15:0] TONE   = 16'h2F74;
  localparam logic [2:0]  G_IDLE  = 3'b000;
  localparam logic [2:0]  G_CLICK = 3'b001;
  localparam logic [2:0]  G_CHIME = 3'b010;
  localparam logic [2:0]  G_ALARM = 3'b100;

  localparam logic [3:0] INJ_NONE  = 4'b0000;
  localparam logic [3:0] INJ_ALARM = 4'b1000;
  localparam logic [3:0] INJ_STOP  = 4'b0100;
  localparam logic [3:0] INJ_CHIME = 4'b0010;
  localparam logic [3:0] INJ_CLICK = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0;
  logic        alarm_req = 1'b0;
  logic        alarm_stop = 1'b0;
  logic        chime_req = 1'b0;
  logic        click_req = 1'b0;
  logic        beep;
  logic [15:0] tone_div;
  logic [2:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  bit tick_en = 1'b1;

  logic [15:0] mel [8] = '{16'h6A88, 16'h8637, 16'h7794, 16'hB327,
                           16'hB327, 16'h7794, 16'h6A88, 16'h8637};

  beep_sched #(
    .CLICK_MS(CLICK_MS), .NOTE_MS(NOTE_MS), .GAP_MS(GAP_MS),
    .ALARM_ON_MS(ON_MS), .ALARM_OFF_MS(OFF_MS), .ALARM_BURSTS(BURSTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms),
    .alarm_req(alarm_req), .alarm_stop(alarm_stop),
    .chime_req(chime_req), .click_req(click_req),
    .beep(beep), .tone_div(tone_div), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Advance one clock; outputs are sampled 1 ns after the edge, and request
  // pulses driven before the call are cleared after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    alarm_req  = 1'b0;
    alarm_stop = 1'b0;
    chime_req  = 1'b0;
    click_req  = 1'b0;
    phase      = (phase + 1) % 4;
    tick_ms    = tick_en && (phase == 0);
  endtask

  task automatic pulse(input logic [3:0] m);
    alarm_req  = m[3];
    alarm_stop = m[2];
    chime_req  = m[1];
    click_req  = m[0];
  endtask

  // One expected segment: current sample is its entry; it must hold g/t until
  // the n-th tick after entry, or (cut) until the injected pulse is taken.
  task automatic seg(input string name, input logic [2:0] g, input logic [15:0] t,
                     input int n, input logic [3:0] inj, input int inj_at, input bit cut);
    int ticks = 0;
    int cn = 0;
    bit bad = 1'b0;
    bit done = 1'b0;
    bit was_tick;
    logic [2:0]  ag = '0;
    logic [15:0] at = '0;
    logic        ab = 1'b0;
    checks++;
    while (!done) begin
      if (!bad && (grant !== g || tone_div !== t || busy !== (g != 3'b000))) begin
        bad = 1'b1; ag = grant; at = tone_div; ab = busy;
      end
      was_tick = tick_ms;
      if (inj != INJ_NONE && cn == inj_at) pulse(inj);
      cyc();
      if (was_tick) ticks++;
      if (cut && inj != INJ_NONE && cn == inj_at) done = 1'b1;
      cn++;
      if (ticks >= n) done = 1'b1;
      if (cn > 4 * n + 8) begin
        done = 1'b1;
        if (!bad) begin bad = 1'b1; ag = grant; at = tone_div; ab = busy; end
      end
    end
    if (bad) begin
      errors++;
      $display("FAIL %s: got grant=%b tone_div=%h busy=%b, expected grant=%b tone_div=%h busy=%b",
               name, ag, at, ab, g, t, (g != 3'b000));
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    bit bad = 1'b0;
    logic [2:0]  ag = '0;
    logic [15:0] at = '0;
    logic        ab = 1'b0;
    logic        abeep = 1'b0;
    checks++;
    for (int i = 0; i < n; i++) begin
      if (!bad && (grant !== G_IDLE || tone_div !== SILENT || busy !== 1'b0 || beep !== 1'b0)) begin
        bad = 1'b1; ag = grant; at = tone_div; ab = busy; abeep = beep;
      end
      cyc();
    end
    if (bad) begin
      errors++;
      $display("FAIL %s: got grant=%b tone_div=%h busy=%b beep=%b, expected idle 000/ffff/0/0",
               name, ag, at, ab, abeep);
    end
  endtask

  function automatic int rand_at(input int n);
    return $urandom_range(0, 4 * (n - 1));
  endfunction

  task automatic chime_notes(input int upto);
    for (int i = 0; i < upto; i++) begin
      seg($sformatf("chime_note%0d", i), G_CHIME, mel[i], NOTE_MS, INJ_NONE, 0, 1'b0);
      seg($sformatf("chime_gap%0d", i), G_CHIME, SILENT, GAP_MS, INJ_NONE, 0, 1'b0);
    end
  endtask

  task automatic chime_full(input int inj_note, input logic [3:0] inj);
    for (int i = 0; i < 8; i++) begin
      seg($sformatf("chime_note%0d", i), G_CHIME, mel[i], NOTE_MS,
          (i == inj_note) ? inj : INJ_NONE, rand_at(NOTE_MS), 1'b0);
      seg($sformatf("chime_gap%0d", i), G_CHIME, SILENT, GAP_MS, INJ_NONE, 0, 1'b0);
    end
  endtask

  task automatic alarm_full(input int inj_b, input bit inj_off, input logic [3:0] inj);
    for (int b = 0; b < BURSTS; b++) begin
      seg($sformatf("alarm_on%0d", b), G_ALARM, TONE, ON_MS,
          (b == inj_b && !inj_off) ? inj : INJ_NONE, rand_at(ON_MS), 1'b0);
      seg($sformatf("alarm_off%0d", b), G_ALARM, SILENT, OFF_MS,
          (b == inj_b && inj_off) ? inj : INJ_NONE, rand_at(OFF_MS), 1'b0);
    end
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    logic [2:0]  ag = '0;
    logic [15:0] at = '0;
    rst_n = 1'b0;
    checks++;
    for (int i = 0; i < 20; i++) begin
      pulse(4'($urandom_range(0, 15)));
      cyc();
      if (!bad && (beep !== 1'b0 || tone_div !== SILENT || grant !== G_IDLE || busy !== 1'b0)) begin
        bad = 1'b1; ag = grant; at = tone_div;
      end
    end
    if (bad) begin
      errors++;
      $display("FAIL reset_hold: got grant=%b tone_div=%h, expected 000/ffff", ag, at);
    end
    rst_n = 1'b1;
    cyc();
    expect_idle("post_reset_idle", 40);

    // Reset in the middle of an alarm with a chime pended leaves nothing behind.
    pulse(INJ_ALARM);
    cyc();
    repeat (3) cyc();
    pulse(INJ_CHIME);
    cyc();
    repeat ($urandom_range(0, 3)) cyc();
    rst_n = 1'b0;
    cyc();
    checks++;
    if (grant !== G_IDLE || tone_div !== SILENT || beep !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_seq: got grant=%b tone_div=%h beep=%b, expected 000/ffff/0",
               grant, tone_div, beep);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_idle("reset_no_residue", 60);
  endtask

  task automatic test_click();
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 7)) cyc();
      pulse(INJ_CLICK);
      cyc();
      seg($sformatf("click%0d", r), G_CLICK, TONE, CLICK_MS,
          ($urandom_range(0, 1) != 0) ? INJ_CLICK : INJ_NONE, rand_at(CLICK_MS), 1'b0);
      expect_idle($sformatf("click%0d_end", r), 8);
    end
  endtask

  task automatic test_click_tone();
    int d = int'(TONE);
    bit bad = 1'b0;
    int bad_k = 0;
    logic exp_b;
    logic act_b = 1'b0;
    tick_en = 1'b0;
    tick_ms = 1'b0;
    cyc();
    pulse(INJ_CLICK);
    cyc();
    checks++;
    for (int k = 0; k < 3 * d + d / 2; k++) begin
      exp_b = 1'((k / d) % 2);
      if (!bad && (beep !== exp_b || grant !== G_CLICK)) begin
        bad = 1'b1; bad_k = k; act_b = beep;
      end
      cyc();
    end
    if (bad) begin
      errors++;
      $display("FAIL click_beep_wave: at clk %0d after grant got beep=%b, expected %b",
               bad_k, act_b, 1'((bad_k / d) % 2));
    end
    tick_en = 1'b1;
    seg("click_long", G_CLICK, TONE, CLICK_MS, INJ_NONE, 0, 1'b0);
    expect_idle("click_long_end", 8);
  endtask

  task automatic test_chime();
    pulse(INJ_CHIME);
    cyc();
    chime_full($urandom_range(0, 7), INJ_CLICK);
    expect_idle("chime_end_click_ignored", 30);
    pulse(INJ_CHIME);
    cyc();
    chime_full($urandom_range(0, 7), INJ_CHIME);
    expect_idle("chime_end_chime_ignored", 30);
  endtask

  task automatic test_preempt();
    int p;
    pulse(INJ_CHIME);
    cyc();
    chime_notes(3);
    seg("pre_note3", G_CHIME, mel[3], NOTE_MS, INJ_ALARM, rand_at(NOTE_MS), 1'b1);
    alarm_full(-1, 1'b0, INJ_NONE);
    expect_idle("pre_note3_no_resume", 40);

    p = $urandom_range(0, 7);
    pulse(INJ_CHIME);
    cyc();
    chime_notes(p);
    seg("pre_gap_note", G_CHIME, mel[p], NOTE_MS, INJ_NONE, 0, 1'b0);
    seg("pre_gap", G_CHIME, SILENT, GAP_MS, INJ_ALARM, 0, 1'b1);
    alarm_full(-1, 1'b0, INJ_NONE);
    expect_idle("pre_gap_no_resume", 40);

    pulse(INJ_CLICK);
    cyc();
    seg("pre_click", G_CLICK, TONE, CLICK_MS, INJ_ALARM, rand_at(CLICK_MS), 1'b1);
    alarm_full(-1, 1'b0, INJ_NONE);
    expect_idle("pre_click_no_resume", 20);
  endtask

  task automatic test_alarm_retrigger();
    pulse(INJ_ALARM);
    cyc();
    alarm_full($urandom_range(0, BURSTS - 1), 1'($urandom_range(0, 1)), INJ_ALARM);
    expect_idle("alarm_retrigger_end", 30);
  endtask

  task automatic test_alarm_stop();
    pulse(INJ_ALARM);
    cyc();
    seg("stop_on0", G_ALARM, TONE, ON_MS, INJ_NONE, 0, 1'b0);
    seg("stop_off0", G_ALARM, SILENT, OFF_MS, INJ_CHIME, rand_at(OFF_MS), 1'b0);
    if ($urandom_range(0, 1) != 0) begin
      seg("stop_on1", G_ALARM, TONE, ON_MS, INJ_STOP, rand_at(ON_MS), 1'b1);
    end else begin
      seg("stop_on1", G_ALARM, TONE, ON_MS, INJ_NONE, 0, 1'b0);
      seg("stop_off1", G_ALARM, SILENT, OFF_MS, INJ_STOP, rand_at(OFF_MS), 1'b1);
    end
    expect_idle("stop_one_idle", 1);
    chime_full(-1, INJ_NONE);
    expect_idle("stop_chime_end", 30);
  endtask

  task automatic test_same_cycle();
    repeat ($urandom_range(0, 5)) cyc();
    pulse(INJ_ALARM | INJ_STOP);
    cyc();
    expect_idle("alarm_and_stop_idle", 40);
    pulse(INJ_ALARM | INJ_CHIME);
    cyc();
    alarm_full(-1, 1'b0, INJ_NONE);
    expect_idle("alarm_chime_one_idle", 1);
    chime_full(-1, INJ_NONE);
    expect_idle("alarm_chime_end", 30);
  endtask

  initial begin
    test_reset();
    test_click();
    test_click_tone();
    test_chime();
    test_preempt();
    test_alarm_retrigger();
    test_alarm_stop();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
